// File: rtl/ptn_gen_chk.sv
// Multi-channel pattern generator (counter / walking-one / PRBS7 / alternating)
// plus a loopback checker that recovers symbol timing, locks and counts errors.
module ptn_gen_chk #(
   parameter int CH_NUM = 8,
   parameter int DIV    = 40,
   parameter int LOCK_N = 8,
   parameter int LOSS_N = 4,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_res_n,
   input  logic              i_en,
   input  logic [1:0]        i_mode,
   input  logic              i_clr,
   input  logic [CH_NUM-1:0] i_rx,
   output logic [CH_NUM-1:0] o_ptn,
   output logic              o_ptn_stb,
   output logic              o_lock,
   output logic              o_err_pulse,
   output logic [CNT_W-1:0]  o_err_cnt
);

   typedef enum logic [1:0] {
      MODE_CNT  = 2'd0,
      MODE_WALK = 2'd1,
      MODE_PRBS = 2'd2,
      MODE_ALT  = 2'd3
   } mode_t;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int MW = $clog2(LOCK_N + 1);
   localparam int LW = $clog2(LOSS_N + 1);

   function automatic logic [CH_NUM-1:0] alt_seed();
      logic [CH_NUM-1:0] p;
      for (int unsigned i = 0; i < CH_NUM; i++) p[i] = ~i[0];
      return p;
   endfunction

   function automatic logic [CH_NUM-1:0] seed_word(input mode_t m);
      case (m)
         MODE_CNT:  seed_word = '0;
         MODE_WALK: seed_word = CH_NUM'(1);
         MODE_ALT:  seed_word = alt_seed();
         default:   seed_word = '1;   // every PRBS seed has bit6 set
      endcase
   endfunction

   function automatic logic [CH_NUM-1:0] step_word(input mode_t m, input logic [CH_NUM-1:0] w);
      case (m)
         MODE_CNT:  step_word = w + CH_NUM'(1);
         MODE_WALK: step_word = {w[CH_NUM-2:0], w[CH_NUM-1]};
         MODE_ALT:  step_word = ~w;
         default:   step_word = w;
      endcase
   endfunction

   mode_t             mode;
   mode_t             mode_q;
   logic              en_q;
   logic              mode_chg;
   logic              load;
   logic [DW-1:0]     div_cnt;
   logic [6:0]        lfsr    [CH_NUM];
   logic [6:0]        lfsr_nx [CH_NUM];
   logic [CH_NUM-1:0] prbs_word;

   assign mode     = mode_t'(i_mode);
   assign mode_chg = (mode != mode_q);
   assign load     = i_en & (~en_q | mode_chg);

   always_comb begin
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         lfsr_nx[k]   = {lfsr[k][5:0], lfsr[k][6] ^ lfsr[k][5]};
         prbs_word[k] = lfsr[k][5];
      end
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         en_q      <= 1'b0;
         mode_q    <= MODE_CNT;
         div_cnt   <= '0;
         o_ptn     <= '0;
         o_ptn_stb <= 1'b0;
         for (int unsigned k = 0; k < CH_NUM; k++) lfsr[k] <= '0;
      end else begin
         en_q      <= i_en;
         mode_q    <= mode;
         o_ptn_stb <= 1'b0;
         if (load) begin
            div_cnt   <= '0;
            o_ptn_stb <= 1'b1;
            o_ptn     <= seed_word(mode);
            for (int unsigned k = 0; k < CH_NUM; k++) lfsr[k] <= {1'b1, k[5:0]};
         end else if (i_en) begin
            if (div_cnt == DW'(DIV - 1)) begin
               div_cnt   <= '0;
               o_ptn_stb <= 1'b1;
               if (mode == MODE_PRBS) begin
                  o_ptn <= prbs_word;
                  for (int unsigned k = 0; k < CH_NUM; k++) lfsr[k] <= lfsr_nx[k];
               end else begin
                  o_ptn <= step_word(mode, o_ptn);
               end
            end else begin
               div_cnt <= div_cnt + DW'(1);
            end
         end
      end
   end

   logic [CH_NUM-1:0] rx_m;
   logic [CH_NUM-1:0] rx_s;
   logic [CH_NUM-1:0] rx_d;
   logic [CH_NUM-1:0] prev;
   logic [CH_NUM-1:0] pred;
   logic [6:0]        hist [CH_NUM];
   logic [DW-1:0]     phase;
   logic              sample_en;
   logic              sample_ok;
   logic              err_event;
   state_t            state;
   state_t            state_nx;
   logic [MW-1:0]     match_cnt;
   logic [MW-1:0]     match_nx;
   logic [LW-1:0]     loss_cnt;
   logic [LW-1:0]     loss_nx;

   // Phase realigns on every word change so sampling lands mid-symbol.
   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         rx_m  <= '0;
         rx_s  <= '0;
         rx_d  <= '0;
         phase <= '0;
      end else begin
         rx_m <= i_rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
         if (rx_s != rx_d || phase == DW'(DIV - 1)) phase <= '0;
         else                                      phase <= phase + DW'(1);
      end
   end

   assign sample_en = (phase == DW'(DIV / 2));

   always_comb begin
      pred = step_word(mode, prev);
      if (mode == MODE_PRBS) begin
         for (int unsigned k = 0; k < CH_NUM; k++) pred[k] = hist[k][6] ^ hist[k][5];
      end
   end

   assign sample_ok = (rx_d == pred);

   always_comb begin
      state_nx  = state;
      match_nx  = match_cnt;
      loss_nx   = loss_cnt;
      err_event = 1'b0;
      if (mode_chg) begin
         state_nx = HUNT;
         match_nx = '0;
         loss_nx  = '0;
      end else if (sample_en) begin
         case (state)
            HUNT: begin
               loss_nx = '0;
               if (!sample_ok) begin
                  match_nx = '0;
               end else if (match_cnt == MW'(LOCK_N - 1)) begin
                  state_nx = LOCKED;
                  match_nx = '0;
               end else begin
                  match_nx = match_cnt + MW'(1);
               end
            end
            default: begin
               if (sample_ok) begin
                  loss_nx = '0;
               end else begin
                  err_event = 1'b1;
                  if (loss_cnt == LW'(LOSS_N - 1)) begin
                     state_nx = HUNT;
                     loss_nx  = '0;
                     match_nx = '0;
                  end else begin
                     loss_nx = loss_cnt + LW'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         state       <= HUNT;
         match_cnt   <= '0;
         loss_cnt    <= '0;
         prev        <= '0;
         o_err_pulse <= 1'b0;
         o_err_cnt   <= '0;
         for (int unsigned k = 0; k < CH_NUM; k++) hist[k] <= '0;
      end else begin
         state       <= state_nx;
         match_cnt   <= match_nx;
         loss_cnt    <= loss_nx;
         o_err_pulse <= err_event;
         if (mode_chg) begin
            prev <= '0;
            for (int unsigned k = 0; k < CH_NUM; k++) hist[k] <= '0;
         end else if (sample_en) begin
            prev <= rx_d;
            for (int unsigned k = 0; k < CH_NUM; k++) hist[k] <= {hist[k][5:0], rx_d[k]};
         end
         if (i_clr)                          o_err_cnt <= '0;
         else if (err_event && o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_W'(1);
      end
   end

   assign o_lock = (state == LOCKED);

endmodule
